// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shifter for the EX stage. One bit per cycle
// through a single accumulator, paced by a down-counter. Raises a stall to the
// hazard unit from the start cycle until the result is ready.
module shift_sequencer #(
  parameter int unsigned N       = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [N-1:0]       a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [N-1:0]       result,
  output logic               stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  state_t             state_q, state_d;
  logic [N-1:0]       acc_q, acc_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [1:0]         op_q, op_d;
  logic [N-1:0]       result_q, result_d;

  // Next-state logic: operand capture, one-bit shift step, result latch.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    count_d  = count_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = a;
          op_d    = op;
          count_d = shamt;
          if (shamt == '0 || op == OP_PASS) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        case (op_q)
          OP_SLL:  acc_d = {acc_q[N-2:0], 1'b0};
          OP_SRL:  acc_d = {1'b0, acc_q[N-1:1]};
          OP_SRA:  acc_d = {acc_q[N-1], acc_q[N-1:1]};
          default: acc_d = acc_q;
        endcase
        count_d = count_q - 1'b1;
        if (count_q == SHAMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Latch the value acc takes on this same edge, so a zero/pass-through
    // request publishes the operand directly without an extra cycle.
    if (state_d == DONE && state_q != DONE) begin
      result_d = acc_d;
    end
  end

  // State registers with synchronous reset; reset discards any in-flight shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      count_q  <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign stall  = ((state_q == IDLE) && start) || (state_q == SHIFT);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus randomized
// shifts compared against an operator-level reference model.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        stall;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] last_result = '0;

    shift_sequencer #(.N(32), .SHAMT_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .shamt  (shamt),
        .busy   (busy),
        .done   (done),
        .result (result),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference result straight from the language shift operators.
    function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [1:0] o, input logic [4:0] s);
        case (o)
            2'b00:   return v << s;
            2'b01:   return v >> s;
            2'b10:   return 32'($signed(v) >>> s);
            default: return v;
        endcase
    endfunction

    // Issue one shift and follow it to completion. With hold=1, start stays
    // high through the whole operation including the done cycle.
    task automatic do_shift(input logic [31:0] va, input logic [1:0] vop, input logic [4:0] vs, input bit hold);
        int unsigned lat;
        int unsigned busy_cnt;
        int unsigned stall_cnt;
        int unsigned done_cnt;
        int unsigned done_at;
        logic [31:0] exp;
        exp = ref_shift(va, vop, vs);
        lat = (vs == 0 || vop == 2'b11) ? 1 : int'(vs) + 1;
        @(posedge clk); #1;
        start = 1'b1; a = va; op = vop; shamt = vs;
        @(negedge clk);
        check_eq("start_stall", 32'(stall), 32'd1);
        check_eq("start_busy", 32'(busy), 32'd0);
        check_eq("held_result", result, last_result);
        busy_cnt = 0; stall_cnt = 1; done_cnt = 0; done_at = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (!hold) begin
                start = 1'b0;
                a = $urandom; op = 2'($urandom); shamt = 5'($urandom);
            end
            @(negedge clk);
            if (busy) busy_cnt++;
            if (stall) stall_cnt++;
            if (busy && done) check_eq("busy_and_done", 32'd1, 32'd0);
            if (done) begin
                done_cnt++;
                done_at = k;
                check_eq("result", result, exp);
                check_eq("stall_in_done", 32'(stall), 32'd0);
                break;
            end
        end
        if (done_cnt == 0) check_eq("timeout_no_done", 32'd0, 32'd1);
        check_eq("latency", done_at, lat);
        check_eq("busy_cycles", busy_cnt, lat - 1);
        check_eq("stall_cycles", stall_cnt, lat);
        last_result = exp;
        if (!hold) start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; a = '0; shamt = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("reset_result", result, 32'h0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_stall", 32'(stall), 32'd0);

        do_shift(32'h0000_0001, 2'b00, 5'd4, 1'b0);
        do_shift(32'h8000_00F0, 2'b10, 5'd31, 1'b0);
        do_shift(32'h8000_00F0, 2'b01, 5'd31, 1'b0);
        do_shift(32'hDEAD_BEEF, 2'b01, 5'd0, 1'b0);
        do_shift(32'hDEAD_BEEF, 2'b11, 5'd7, 1'b0);
        // Start held through SHIFT and DONE, then accepted again right away.
        do_shift(32'h0000_0080, 2'b01, 5'd3, 1'b1);
        do_shift(32'h0000_0F00, 2'b00, 5'd2, 1'b0);

        // Reset in the 10th SHIFT cycle of a 20-bit SLL.
        @(posedge clk); #1;
        start = 1'b1; a = 32'h0000_0001; op = 2'b00; shamt = 5'd20;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("pre_reset_busy", 32'(busy), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("midreset_result", result, 32'h0);
            check_eq("midreset_done", 32'(done), 32'd0);
            check_eq("midreset_busy", 32'(busy), 32'd0);
            @(posedge clk);
        end
        last_result = '0;
        do_shift(32'h0000_0003, 2'b00, 5'd1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            do_shift($urandom, 2'($urandom), 5'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
